if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the program counter, drives the word address into Instruction_Mem
//  and captures the returned word into the IF/ID pipeline register.
//  Consumes the combinational instruction memory (zero-latency read).
//  Honours hazard-unit freeze, pipeline flush and EXE-stage branch redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  byte address loaded into PC on reset
//  NOP_INSTR  32'h0000_0000  word injected into IF/ID on flush/redirect (matches memory default)
// PORTS
//  clk           in   1             rising-edge clock
//  rst           in   1             synchronous, active-high reset
//  freeze        in   1             hazard stall: hold PC and IF/ID
//  flush         in   1             kill the instruction entering IF/ID
//  branch_taken  in   1             EXE-stage redirect request
//  branch_addr   in   `WORD_WIDTH   redirect target, byte address; bits [1:0] ignored
//  imem_addr     out  `WORD_WIDTH   word index to instruction memory = {2'b00, pc[31:2]}
//  imem_instr    in   `WORD_WIDTH   instruction word returned by memory (same cycle)
//  if_id_pc      out  `WORD_WIDTH   PC+4 of the captured instruction
//  if_id_instr   out  `WORD_WIDTH   captured instruction
//  if_id_valid   out  1             captured instruction is live
//  halted        out  1             halt-loop detected (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (wins over every other input): pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0.
//  - imem_addr is combinational from pc. The instruction at pc appears on if_id_* one edge later.
//  - PC update priority, per edge:
//    1. rst
//    2. halted -> hold
//    3. branch_taken -> pc = {branch_addr[31:2], 2'b00}
//    4. freeze -> hold
//    5. otherwise pc = pc + 4
//  - PC arithmetic is modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0; no flag is raised.
//  - IF/ID update priority, per edge:
//    1. rst
//    2. flush | branch_taken | halted -> instr=NOP_INSTR, pc=0, valid=0
//    3. freeze -> hold all three
//    4. otherwise instr=imem_instr, pc=pc+4, valid=1
//  - branch_taken together with freeze: the redirect wins. PC loads the target and IF/ID is flushed.
//  - flush without branch: PC still advances unless freeze is also high.
//  - flush together with freeze: IF/ID is cleared and PC holds.
//  - No internal state other than pc, the IF/ID register and the halted flag.
// CONFIGURATION
//  Macro FETCH_HALT_DETECT_EN.
//  - Defined:
//    - When an edge would capture imem_instr == 32'hEAFF_FFFF (B #-1) with valid=1, that word is
//      captured normally and halted is set on the same edge.
//    - halted is sticky until rst. While it is set, PC holds, IF/ID delivers NOP with valid=0,
//      and branch_taken is ignored.
//  - Undefined: halted is tied to 0, and B #-1 is fetched like any other branch.
// TESTING
//  1. rst 1 cycle, then 4 free-running cycles:
//     - imem_addr = 0,1,2,3
//     - if_id_pc = 4,8,12
//     - if_id_valid = 1 from the 2nd edge
//  2. freeze high 2 cycles with pc=8: imem_addr stays 2; if_id_instr/pc/valid unchanged; resumes at addr 3.
//  3. branch_taken, branch_addr=0x90, at pc=0x10:
//     - next imem_addr = 0x24
//     - if_id_valid = 0 and if_id_instr = 0 for one cycle
//     - then the word at index 0x24 is captured with if_id_pc = 0x94
//  4. branch_taken, freeze and flush together, branch_addr=0x93: pc = 0x90 (low bits dropped); IF/ID cleared.
//  5. flush alone at pc=8: next imem_addr = 3; if_id_valid = 0 for that edge only.
//  6. FETCH_HALT_DETECT_EN, imem_instr = 32'hEAFF_FFFF at pc=0xB8:
//     - halted = 1 after the edge; if_id_instr = 0xEAFF_FFFF with valid = 1
//     - afterwards imem_addr stays 46 and if_id_valid = 0
//     - branch_taken is ignored; rst clears halted

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction-memory port, IF/ID outputs.
// master: fetch stage (drives imem_addr, if_id_*, halted); slave: surrounding pipeline/memory.
// Pure wiring, no latency and no backpressure of its own.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface if_fetch_stage_if;
    logic                   freeze;
    logic                   flush;
    logic                   branch_taken;
    logic [`WORD_WIDTH-1:0] branch_addr;
    logic [`WORD_WIDTH-1:0] imem_addr;
    logic [`WORD_WIDTH-1:0] imem_instr;
    logic [`WORD_WIDTH-1:0] if_id_pc;
    logic [`WORD_WIDTH-1:0] if_id_instr;
    logic                   if_id_valid;
    logic                   halted;

    modport master (
        input  freeze, flush, branch_taken, branch_addr, imem_instr,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, halted
    );

    modport slave (
        output freeze, flush, branch_taken, branch_addr, imem_instr,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, halted
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, addresses a zero-latency instruction memory, fills IF/ID.
// Latency: the word at pc appears on if_id_* one clock edge after pc presents it.
// Backpressure: freeze holds PC and IF/ID; flush/redirect inject NOP; halt (optional) parks the stage.
// Ports: clk, rst (sync, active-high), bus (if_fetch_stage_if.master: freeze, flush, branch_taken,
//        branch_addr, imem_addr, imem_instr, if_id_pc, if_id_instr, if_id_valid, halted).
// Optional feature: define FETCH_HALT_DETECT_EN to detect the "B #-1" self-loop and halt fetch.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module if_fetch_stage #(
    parameter logic [`WORD_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [`WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_stage_if.master   bus
);

    localparam logic [`WORD_WIDTH-1:0] HALT_INSTR = 32'hEAFF_FFFF;

    logic [`WORD_WIDTH-1:0] pc;
    logic [`WORD_WIDTH-1:0] pc_plus4;
    logic [`WORD_WIDTH-1:0] if_id_pc_q;
    logic [`WORD_WIDTH-1:0] if_id_instr_q;
    logic                   if_id_valid_q;
    logic                   halted_q;
    logic                   halt_hit;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc + 32'd4;

    assign bus.imem_addr   = {2'b00, pc[`WORD_WIDTH-1:2]};
    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.halted      = halted_q;

`ifdef FETCH_HALT_DETECT_EN
    // Only a word that would actually be captured as valid can trigger the halt.
    assign halt_hit = !halted_q && !bus.flush && !bus.branch_taken && !bus.freeze &&
                      (bus.imem_instr == HALT_INSTR);

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (halt_hit) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halt_hit = 1'b0;
    assign halted_q = 1'b0;
`endif

    // PC: halt > redirect > freeze > advance. The branch-to-self word is its own
    // target, so the PC already parks on it during the detecting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (halted_q || halt_hit) begin
            pc <= pc;
        end else if (bus.branch_taken) begin
            pc <= {bus.branch_addr[`WORD_WIDTH-1:2], 2'b00};
        end else if (!bus.freeze) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID: kill beats freeze, so a redirect under stall still squashes the wrong-path word.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else if (bus.flush || bus.branch_taken || halted_q) begin
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else if (!bus.freeze) begin
            if_id_pc_q    <= pc_plus4;
            if_id_instr_q <= bus.imem_instr;
            if_id_valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: stimulus queues hand-computed post-edge expectations,
// a monitor pops one entry per clock edge and compares every output field.
// Memory model: word index i returns {8'hA5, i[23:0]}, except index 46 which returns B #-1.
module tb_if_fetch_stage;

    logic clk;
    logic rst;
    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (bus.imem_addr == 32'd46) bus.imem_instr = 32'hEAFF_FFFF;
        else                         bus.imem_instr = {8'hA5, bus.imem_addr[23:0]};
    end

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
        end
    endtask

    // Monitor: every edge produces a new output state; check it shortly after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                cmp(e.name, "imem_addr",   bus.imem_addr,           e.addr);
                cmp(e.name, "if_id_pc",    bus.if_id_pc,            e.pc);
                cmp(e.name, "if_id_instr", bus.if_id_instr,         e.instr);
                cmp(e.name, "if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
                cmp(e.name, "halted",      {31'd0, bus.halted},      {31'd0, e.halted});
            end
        end
    end

    task automatic step(input logic r, input logic fz, input logic fl, input logic br,
                        input logic [31:0] ba, input logic [31:0] ea, input logic [31:0] ep,
                        input logic [31:0] ei, input logic ev, input logic eh, input string nm);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.freeze       = fz;
        bus.flush        = fl;
        bus.branch_taken = br;
        bus.branch_addr  = ba;
        e.name = nm; e.addr = ea; e.pc = ep; e.instr = ei; e.valid = ev; e.halted = eh;
        expq.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; bus.freeze = 1'b0; bus.flush = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_addr = '0;

        //    rst fz fl br baddr          addr          if_id_pc      if_id_instr    v  h
        step(1, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'h0,         0, 0, "reset");
        step(0, 0, 0, 0, 32'h0,         32'h1,        32'h4,        32'hA500_0000, 1, 0, "run1");
        step(0, 0, 0, 0, 32'h0,         32'h2,        32'h8,        32'hA500_0001, 1, 0, "run2");
        // freeze two cycles at pc=8
        step(0, 1, 0, 0, 32'h0,         32'h2,        32'h8,        32'hA500_0001, 1, 0, "frz1");
        step(0, 1, 0, 0, 32'h0,         32'h2,        32'h8,        32'hA500_0001, 1, 0, "frz2");
        step(0, 0, 0, 0, 32'h0,         32'h3,        32'hC,        32'hA500_0002, 1, 0, "resume");
        step(0, 0, 0, 0, 32'h0,         32'h4,        32'h10,       32'hA500_0003, 1, 0, "run3");
        // redirect to 0x90 at pc=0x10
        step(0, 0, 0, 1, 32'h90,        32'h24,       32'h0,        32'h0,         0, 0, "br90");
        step(0, 0, 0, 0, 32'h0,         32'h25,       32'h94,       32'hA500_0024, 1, 0, "br_tgt");
        // flush alone at pc=8
        step(0, 0, 0, 1, 32'h8,         32'h2,        32'h0,        32'h0,         0, 0, "br8");
        step(0, 0, 1, 0, 32'h0,         32'h3,        32'h0,        32'h0,         0, 0, "flush");
        step(0, 0, 0, 0, 32'h0,         32'h4,        32'h10,       32'hA500_0003, 1, 0, "post_flush");
        // redirect + freeze + flush, unaligned target
        step(0, 1, 1, 1, 32'h93,        32'h24,       32'h0,        32'h0,         0, 0, "br_frz_fl");
        step(0, 1, 0, 0, 32'h0,         32'h24,       32'h0,        32'h0,         0, 0, "frz_hold");
        step(0, 0, 0, 0, 32'h0,         32'h25,       32'h94,       32'hA500_0024, 1, 0, "run4");
        // flush + freeze: clear IF/ID, hold PC
        step(0, 1, 1, 0, 32'h0,         32'h25,       32'h0,        32'h0,         0, 0, "fl_frz");
        step(0, 0, 0, 0, 32'h0,         32'h26,       32'h98,       32'hA500_0025, 1, 0, "run5");
        // PC wrap at top of address space
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0,       32'h0,         0, 0, "br_top");
        step(0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        32'hA5FF_FFFF, 1, 0, "wrap");
        // self-loop word at 0xB8
        step(0, 0, 0, 1, 32'hB8,        32'h2E,       32'h0,        32'h0,         0, 0, "brB8");
`ifdef FETCH_HALT_DETECT_EN
        step(0, 0, 0, 0, 32'h0,         32'h2E,       32'hBC,       32'hEAFF_FFFF, 1, 1, "halt_hit");
        step(0, 0, 0, 0, 32'h0,         32'h2E,       32'h0,        32'h0,         0, 1, "halted");
        step(0, 0, 0, 1, 32'h10,        32'h2E,       32'h0,        32'h0,         0, 1, "halt_br");
`else
        step(0, 0, 0, 0, 32'h0,         32'h2F,       32'hBC,       32'hEAFF_FFFF, 1, 0, "b_self");
        step(0, 0, 0, 0, 32'h0,         32'h30,       32'hC0,       32'hA500_002F, 1, 0, "b_next");
        step(0, 0, 0, 1, 32'h10,        32'h4,        32'h0,        32'h0,         0, 0, "b_br");
`endif
        step(1, 0, 0, 1, 32'h40,        32'h0,        32'h0,        32'h0,         0, 0, "rst_wins");
        step(0, 0, 0, 0, 32'h0,         32'h1,        32'h4,        32'hA500_0000, 1, 0, "run_after");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
